// File: rtl/delay_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : delay_sched_pkg
//  Purpose  : Shared definitions for the delayed write scheduler: the
//             delay-select encoding and the default geometry constants.
//  Revision : 1.0 - initial release
// ============================================================================
package delay_sched_pkg;

    // Delay-select encoding. The spare code 2'b11 also means "typical".
    typedef enum logic [1:0] {
        DLY_MIN     = 2'b00,
        DLY_TYP     = 2'b01,
        DLY_MAX     = 2'b10,
        DLY_TYP_ALT = 2'b11
    } dly_sel_e;

    localparam int unsigned c_DEFAULT_DW    = 4;
    localparam int unsigned c_DEFAULT_DEPTH = 4;
    localparam int unsigned c_DEFAULT_CW    = 5;

endpackage
`default_nettype wire

// File: rtl/dly_slot.sv
`default_nettype none
// ============================================================================
//  Module   : dly_slot
//  Purpose  : One pending-write slot: valid flag, data, delay down-counter,
//             zero (eligible) flag and issue-order rank.
//  Ports    : clk, rst_n        - clock, async active-low reset
//             i_load            - load this slot (data, count, rank)
//             i_data/i_count/i_tag - values loaded on i_load
//             i_free            - this slot commits at this edge
//             i_cmt/i_cmt_tag   - some slot commits, and its rank
//             o_valid/o_data/o_zero/o_tag - slot state
//  Revision : 1.0 - initial release
// ============================================================================
module dly_slot #(
    parameter int DW = 4,
    parameter int CW = 5,
    parameter int TW = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_load,
    input  logic [DW-1:0] i_data,
    input  logic [CW-1:0] i_count,
    input  logic [TW-1:0] i_tag,
    input  logic          i_free,
    input  logic          i_cmt,
    input  logic [TW-1:0] i_cmt_tag,
    output logic          o_valid,
    output logic [DW-1:0] o_data,
    output logic          o_zero,
    output logic [TW-1:0] o_tag
);

    logic          r_valid;
    logic [DW-1:0] r_data;
    logic [CW-1:0] r_cnt;
    logic [TW-1:0] r_tag;

    // The tag is the slot's rank among occupied slots (0 = oldest). When an
    // older slot commits, every younger slot moves one rank closer to 0, so
    // ranks stay dense and unique without any wrap-around handling.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_cnt   <= '0;
            r_tag   <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_cnt   <= i_count;
            r_tag   <= i_tag;
        end else if (i_free) begin
            r_valid <= 1'b0;
        end else if (r_valid) begin
            if (r_cnt != '0) begin
                r_cnt <= r_cnt - CW'(1);
            end
            if (i_cmt && (r_tag > i_cmt_tag)) begin
                r_tag <= r_tag - TW'(1);
            end
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_zero  = r_valid && (r_cnt == '0);
    assign o_tag   = r_tag;

endmodule
`default_nettype wire

// File: rtl/delayed_write_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : delayed_write_scheduler
//  Purpose  : Accepts write requests, holds each for a selectable delay and
//             commits them one per cycle (oldest first among expired ones)
//             into a single committed value register.
//  Ports    : clk, rst_n                 - clock, async active-low reset
//             min_dly/typ_dly/max_dly    - configured delays (cycles)
//             dly_sel                    - delay select (see delay_sched_pkg)
//             req_valid/req_data/req_ready - request handshake
//             value_q/value_valid        - committed value and its validity
//             commit                     - one-cycle pulse per commit
//             pending                    - number of occupied slots
//  Revision : 1.0 - initial release
// ============================================================================
module delayed_write_scheduler
    import delay_sched_pkg::*;
#(
    parameter int DW    = c_DEFAULT_DW,
    parameter int DEPTH = c_DEFAULT_DEPTH,
    parameter int CW    = c_DEFAULT_CW
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [CW-1:0]              min_dly,
    input  logic [CW-1:0]              typ_dly,
    input  logic [CW-1:0]              max_dly,
    input  logic [1:0]                 dly_sel,
    input  logic                       req_valid,
    input  logic [DW-1:0]              req_data,
    output logic                       req_ready,
    output logic [DW-1:0]              value_q,
    output logic                       value_valid,
    output logic                       commit,
    output logic [$clog2(DEPTH+1)-1:0] pending
);

    localparam int PW = $clog2(DEPTH + 1);
    localparam int TW = $clog2(DEPTH);

    logic [DEPTH-1:0] w_valid;
    logic [DEPTH-1:0] w_zero;
    logic [DEPTH-1:0] w_load;
    logic [DW-1:0]    w_data [DEPTH];
    logic [TW-1:0]    w_tag  [DEPTH];

    logic             w_accept;
    logic             w_alloc_found;
    logic [CW-1:0]    w_dly;
    logic [TW-1:0]    w_new_tag;
    logic             w_cmt;
    logic [TW-1:0]    w_cmt_idx;
    logic [TW-1:0]    w_cmt_tag;

    logic [DW-1:0]    r_value;
    logic             r_value_valid;
    logic             r_commit;
    logic [PW-1:0]    r_pending;

    assign req_ready = ~(&w_valid);
    assign w_accept  = req_valid && req_ready;

    always_comb begin
        case (dly_sel_e'(dly_sel))
            DLY_MIN: w_dly = min_dly;
            DLY_MAX: w_dly = max_dly;
            default: w_dly = typ_dly;
        endcase
    end

    // Lowest free index receives the new request.
    always_comb begin
        w_load        = '0;
        w_alloc_found = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!w_valid[i] && !w_alloc_found) begin
                w_load[i]     = w_accept;
                w_alloc_found = 1'b1;
            end
        end
    end

    // Among expired slots, the one with the smallest rank (oldest) commits.
    always_comb begin
        w_cmt     = 1'b0;
        w_cmt_idx = '0;
        w_cmt_tag = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_zero[i] && (!w_cmt || (w_tag[i] < w_cmt_tag))) begin
                w_cmt     = 1'b1;
                w_cmt_idx = TW'(i);
                w_cmt_tag = w_tag[i];
            end
        end
    end

    // A newcomer ranks behind every slot still occupied after this edge.
    assign w_new_tag = TW'(r_pending - PW'(w_cmt));

    for (genvar g = 0; g < DEPTH; g++) begin : g_slot
        dly_slot #(
            .DW (DW),
            .CW (CW),
            .TW (TW)
        ) u_slot (
            .clk       (clk),
            .rst_n     (rst_n),
            .i_load    (w_load[g]),
            .i_data    (req_data),
            .i_count   (w_dly),
            .i_tag     (w_new_tag),
            .i_free    (w_cmt && (w_cmt_idx == TW'(g))),
            .i_cmt     (w_cmt),
            .i_cmt_tag (w_cmt_tag),
            .o_valid   (w_valid[g]),
            .o_data    (w_data[g]),
            .o_zero    (w_zero[g]),
            .o_tag     (w_tag[g])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_value       <= '0;
            r_value_valid <= 1'b0;
            r_commit      <= 1'b0;
            r_pending     <= '0;
        end else begin
            r_commit  <= w_cmt;
            r_pending <= r_pending + PW'(w_accept) - PW'(w_cmt);
            if (w_cmt) begin
                r_value       <= w_data[w_cmt_idx];
                r_value_valid <= 1'b1;
            end
        end
    end

    assign value_q     = r_value;
    assign value_valid = r_value_valid;
    assign commit      = r_commit;
    assign pending     = r_pending;

endmodule
`default_nettype wire

// File: tb/tb_delayed_write_scheduler.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_delayed_write_scheduler
//  Purpose  : Self-checking bench for delayed_write_scheduler. A queue-based
//             model tracks each accepted write's earliest commit edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_delayed_write_scheduler;

    localparam int DW    = 4;
    localparam int DEPTH = 4;
    localparam int CW    = 5;
    localparam int PW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [CW-1:0] min_dly = '0;
    logic [CW-1:0] typ_dly = '0;
    logic [CW-1:0] max_dly = '0;
    logic [1:0]    dly_sel = '0;
    logic          req_valid = 1'b0;
    logic [DW-1:0] req_data = '0;
    logic          req_ready;
    logic [DW-1:0] value_q;
    logic          value_valid;
    logic          commit;
    logic [PW-1:0] pending;

    always #5 clk = ~clk;

    delayed_write_scheduler #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .CW    (CW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .min_dly     (min_dly),
        .typ_dly     (typ_dly),
        .max_dly     (max_dly),
        .dly_sel     (dly_sel),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .value_q     (value_q),
        .value_valid (value_valid),
        .commit      (commit),
        .pending     (pending)
    );

    // Reference model: writes in issue order, each with the first edge at
    // which it may commit (acceptance edge + delay + 1).
    typedef struct {
        logic [DW-1:0] data;
        int            rdy;
    } ent_t;

    ent_t          mq[$];
    logic [DW-1:0] m_value = '0;
    logic          m_valid = 1'b0;
    logic          m_commit = 1'b0;
    int            edge_n = 0;
    int            cmt_edges[$];
    int            t0;
    int            n_cmp = 0;
    int            n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, edge_n);
        end
    endtask

    // One clock cycle: drive at the falling edge, advance the model on the
    // rising edge, compare outputs at the next falling edge.
    task automatic step(input logic v, input logic [DW-1:0] d, input logic [1:0] s);
        int  dly;
        bit  acc;
        bit  done;
        req_valid = v;
        req_data  = d;
        dly_sel   = s;
        case (s)
            2'b00:   dly = int'(min_dly);
            2'b10:   dly = int'(max_dly);
            default: dly = int'(typ_dly);
        endcase
        acc = v && (mq.size() < DEPTH);
        #1;
        check_val("req_ready", {31'd0, req_ready}, {31'd0, (mq.size() < DEPTH)});
        @(posedge clk);
        edge_n++;
        m_commit = 1'b0;
        done = 1'b0;
        for (int i = 0; i < mq.size(); i++) begin
            if (!done && mq[i].rdy <= edge_n) begin
                m_value  = mq[i].data;
                m_valid  = 1'b1;
                m_commit = 1'b1;
                mq.delete(i);
                done = 1'b1;
            end
        end
        if (acc) mq.push_back('{data: d, rdy: edge_n + dly + 1});
        @(negedge clk);
        if (commit === 1'b1) cmt_edges.push_back(edge_n);
        check_val("value_q",     {28'd0, value_q},     {28'd0, m_value});
        check_val("value_valid", {31'd0, value_valid}, {31'd0, m_valid});
        check_val("commit",      {31'd0, commit},      {31'd0, m_commit});
        check_val("pending",     {29'd0, pending},     32'(mq.size()));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 2'b01);
    endtask

    task automatic do_reset();
        req_valid = 1'b0;
        rst_n     = 1'b0;
        #1;
        mq.delete();
        m_value  = '0;
        m_valid  = 1'b0;
        m_commit = 1'b0;
        check_val("rst_pending",     {29'd0, pending},     32'd0);
        check_val("rst_value_valid", {31'd0, value_valid}, 32'd0);
        check_val("rst_commit",      {31'd0, commit},      32'd0);
        check_val("rst_value_q",     {28'd0, value_q},     32'd0);
        check_val("rst_req_ready",   {31'd0, req_ready},   32'd1);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Compare the commit edges recorded since t0 against expected offsets.
    task automatic check_edges(input string tag, input int e0, input int e1, input int n);
        check_val({tag, "_ncommit"}, 32'(cmt_edges.size()), 32'(n));
        if (cmt_edges.size() >= 1) check_val({tag, "_edge0"}, 32'(cmt_edges[0] - t0), 32'(e0));
        if (n > 1 && cmt_edges.size() >= 2) check_val({tag, "_edge1"}, 32'(cmt_edges[1] - t0), 32'(e1));
    endtask

    initial begin
        @(negedge clk);
        do_reset();

        // Single typical-delay write.
        min_dly = 5'd2; typ_dly = 5'd10; max_dly = 5'd17;
        cmt_edges.delete(); t0 = edge_n + 1;
        step(1'b1, 4'h5, 2'b01);
        idle(14);
        check_edges("s_typ", 11, 0, 1);
        check_val("s_typ_value", {28'd0, value_q}, 32'h5);

        // Short then long: issue order kept.
        cmt_edges.delete(); t0 = edge_n + 1;
        step(1'b1, 4'h3, 2'b00);
        step(1'b1, 4'h9, 2'b10);
        idle(20);
        check_edges("s_minmax", 3, 19, 2);
        check_val("s_minmax_value", {28'd0, value_q}, 32'h9);

        // Long then short: the later short write overtakes.
        cmt_edges.delete(); t0 = edge_n + 1;
        step(1'b1, 4'hA, 2'b10);
        step(1'b1, 4'h6, 2'b00);
        idle(20);
        check_edges("s_overtake", 4, 18, 2);
        check_val("s_overtake_value", {28'd0, value_q}, 32'hA);

        // Zero delay, back to back.
        typ_dly = 5'd0;
        cmt_edges.delete(); t0 = edge_n + 1;
        for (int i = 1; i <= 4; i++) step(1'b1, DW'(i), 2'b01);
        idle(4);
        check_val("s_zero_ncommit", 32'(cmt_edges.size()), 32'd4);
        for (int i = 0; i < cmt_edges.size() && i < 4; i++)
            check_val("s_zero_edge", 32'(cmt_edges[i] - t0), 32'(i + 1));
        check_val("s_zero_value", {28'd0, value_q}, 32'h4);

        // Equal expiry: earlier issue wins, one commit per edge.
        min_dly = 5'd3; typ_dly = 5'd2;
        cmt_edges.delete(); t0 = edge_n + 1;
        step(1'b1, 4'h1, 2'b00);
        step(1'b1, 4'h2, 2'b01);
        idle(8);
        check_edges("s_tie", 4, 5, 2);
        check_val("s_tie_value", {28'd0, value_q}, 32'h2);

        // Mid-operation reset discards pending writes.
        min_dly = 5'd2; typ_dly = 5'd10; max_dly = 5'd17;
        step(1'b1, 4'h7, 2'b10);
        step(1'b1, 4'h8, 2'b10);
        step(1'b1, 4'hB, 2'b01);
        idle(2);
        check_val("s_rst_pre_pending", {29'd0, pending}, 32'd3);
        do_reset();
        cmt_edges.delete();
        idle(40);
        check_val("s_rst_ncommit", 32'(cmt_edges.size()), 32'd0);

        // Randomized traffic across several delay configurations.
        for (int cfg = 0; cfg < 6; cfg++) begin
            min_dly = CW'($urandom_range(0, 3));
            typ_dly = CW'($urandom_range(0, 6));
            max_dly = CW'((cfg == 5) ? $urandom_range(20, 31) : $urandom_range(0, 9));
            for (int n = 0; n < 300; n++) begin
                if (cfg == 4) begin
                    min_dly = CW'($urandom_range(0, 7));
                    typ_dly = CW'($urandom_range(0, 7));
                    max_dly = CW'($urandom_range(0, 15));
                end
                if (n == 150 && cfg[0]) do_reset();
                step(1'($urandom_range(0, 3) != 0), DW'($urandom), 2'($urandom));
            end
            idle(35);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
